// File: rtl/labyrinth_pkg.sv
// Shared definitions for the labyrinth ball input path: per-channel move FSM
// encoding and the direction channel indices.
package labyrinth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } move_state_t;

  localparam int unsigned DIR_UP    = 0;
  localparam int unsigned DIR_DOWN  = 1;
  localparam int unsigned DIR_LEFT  = 2;
  localparam int unsigned DIR_RIGHT = 3;

endpackage

// File: rtl/move_repeat_chan.sv
// One direction channel: press pulse, delayed first repeat, then auto-repeat
// with an optional shrinking period.
module move_repeat_chan
  import labyrinth_pkg::*;
#(
  parameter int unsigned DELAY_T      = 400,
  parameter int unsigned REPEAT_T     = 100,
  parameter int unsigned MIN_REPEAT_T = 25,
  parameter int unsigned ACCEL_STEP_T = 25,
  parameter int unsigned CNT_W        = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic eff_i,
  input  logic base_tick_i,
  input  logic accel_en_i,
  output logic move_o,
  output logic held_o
);

  localparam logic [CNT_W-1:0] DelayLast  = CNT_W'(DELAY_T - 1);
  localparam logic [CNT_W-1:0] RepeatInit = CNT_W'(REPEAT_T);
  localparam logic [CNT_W-1:0] MinPer     = CNT_W'(MIN_REPEAT_T);
  localparam logic [CNT_W-1:0] Step       = CNT_W'(ACCEL_STEP_T);
  localparam logic [CNT_W-1:0] One        = CNT_W'(1);

  move_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] per_next;
  logic             move_q, move_d;

  // Saturating shrink: never wraps below zero and never drops under the floor.
  always_comb begin
    per_next = per_q - Step;
    if (per_q <= Step || per_next < MinPer) begin
      per_next = MinPer;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    move_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (eff_i) begin
          move_d  = 1'b1;
          state_d = DELAY;
          cnt_d   = '0;
        end
      end
      DELAY: begin
        if (!eff_i) begin
          state_d = IDLE;
        end else if (base_tick_i) begin
          if (cnt_q == DelayLast) begin
            move_d  = 1'b1;
            state_d = REPEAT;
            cnt_d   = '0;
            per_d   = RepeatInit;
          end else begin
            cnt_d = cnt_q + One;
          end
        end
      end
      REPEAT: begin
        if (!eff_i) begin
          state_d = IDLE;
        end else if (base_tick_i) begin
          if (cnt_q == per_q - One) begin
            move_d = 1'b1;
            cnt_d  = '0;
            if (accel_en_i) begin
              per_d = per_next;
            end
          end else begin
            cnt_d = cnt_q + One;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      per_q   <= RepeatInit;
      move_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      move_q  <= move_d;
    end
  end

  assign move_o = move_q;
  assign held_o = (state_q != IDLE);

endmodule

// File: rtl/move_repeat_ctrl.sv
// Direction-input controller: shared prescaler, opposing-pair masking and one
// press/hold/auto-repeat channel per direction.
module move_repeat_ctrl
  import labyrinth_pkg::*;
#(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned BASE_HZ      = 1000,
  parameter int unsigned DELAY_T      = 400,
  parameter int unsigned REPEAT_T     = 100,
  parameter int unsigned MIN_REPEAT_T = 25,
  parameter int unsigned ACCEL_STEP_T = 25,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              accel_en,
  input  logic [NUM_CH-1:0] btn_in,
  output logic [NUM_CH-1:0] move_out,
  output logic [NUM_CH-1:0] held_out,
  output logic              base_tick
);

  localparam int unsigned Div   = CLK_HZ / BASE_HZ;
  localparam int unsigned PresW = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [PresW-1:0] PresTop = PresW'(Div - 1);
  localparam logic [PresW-1:0] PresOne = PresW'(1);

  logic [PresW-1:0]  pres_q, pres_d;
  logic [NUM_CH-1:0] eff;

  assign base_tick = (pres_q == PresTop);

  always_comb begin
    pres_d = pres_q + PresOne;
    if (base_tick) begin
      pres_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pres_q <= '0;
    end else begin
      pres_q <= pres_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : gen_chan
    // Both buttons of an opposing pair held reads as neither pressed.
    assign eff[g] = enable & btn_in[g] & ~btn_in[g ^ 1];

    move_repeat_chan #(
      .DELAY_T     (DELAY_T),
      .REPEAT_T    (REPEAT_T),
      .MIN_REPEAT_T(MIN_REPEAT_T),
      .ACCEL_STEP_T(ACCEL_STEP_T),
      .CNT_W       (CNT_W)
    ) u_chan (
      .clk_i      (clk),
      .rst_i      (reset),
      .eff_i      (eff[g]),
      .base_tick_i(base_tick),
      .accel_en_i (accel_en),
      .move_o     (move_out[g]),
      .held_o     (held_out[g])
    );
  end

endmodule

// File: tb/tb_move_repeat_ctrl.sv
// Directed bench for move_repeat_ctrl: tap, hold, accel, opposing pair,
// enable/reset and release-on-tick, all timed from a base_tick cycle (cycle 0).
module tb_move_repeat_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       accel_en;
  logic [3:0] btn_in;
  logic [3:0] move_out;
  logic [3:0] held_out;
  logic       base_tick;

  int errors = 0;
  int checks = 0;
  int k;
  logic [3:0] mv [0:255];
  logic [3:0] hd [0:255];
  logic       tk [0:255];

  move_repeat_ctrl #(
    .NUM_CH      (4),
    .CLK_HZ      (1000),
    .BASE_HZ     (100),
    .DELAY_T     (4),
    .REPEAT_T    (3),
    .MIN_REPEAT_T(1),
    .ACCEL_STEP_T(1),
    .CNT_W       (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .accel_en (accel_en),
    .btn_in   (btn_in),
    .move_out (move_out),
    .held_out (held_out),
    .base_tick(base_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step_rec();
    @(posedge clk);
    #1;
    k++;
    mv[k] = move_out;
    hd[k] = held_out;
    tk[k] = base_tick;
  endtask

  task automatic run_to(input int target);
    while (k < target) step_rec();
  endtask

  // Leaves the bench inside a base_tick cycle, which becomes cycle 0.
  task automatic sync_tick();
    for (int i = 0; i < 30 && !base_tick; i++) begin
      @(posedge clk);
      #1;
    end
    chk("sync_tick", base_tick, 1);
    k = 0;
  endtask

  function automatic int count(input int ch, input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) n += int'(mv[i][ch]);
    return n;
  endfunction

  initial begin
    reset    = 1'b1;
    enable   = 1'b0;
    accel_en = 1'b0;
    btn_in   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_move", move_out, 0);
    chk("rst_held", held_out, 0);
    chk("rst_tick", base_tick, 0);
    reset  = 1'b0;
    enable = 1'b1;

    // Tap: button high in cycles 0 and 1
    sync_tick();
    btn_in[0] = 1'b1;
    run_to(2);
    btn_in[0] = 1'b0;
    run_to(20);
    chk("tap_pulse", mv[1][0], 1);
    chk("tap_nopulse2", mv[2][0], 0);
    chk("tap_count", count(0, 1, 20), 1);
    chk("tap_held1", hd[1][0], 1);
    chk("tap_held2", hd[2][0], 1);
    chk("tap_held3", hd[3][0], 0);
    chk("pres_t9", tk[9], 0);
    chk("pres_t10", tk[10], 1);

    // Hold: released in cycle 100, which is also the tick ending a period
    sync_tick();
    btn_in[2] = 1'b1;
    run_to(100);
    btn_in[2] = 1'b0;
    run_to(110);
    chk("hold_press", mv[1][2], 1);
    chk("hold_early", mv[40][2], 0);
    chk("hold_first_rep", mv[41][2], 1);
    chk("hold_second_rep", mv[71][2], 1);
    chk("hold_tick100", tk[100], 1);
    chk("collision_nopulse", mv[101][2], 0);
    chk("hold_count", count(2, 1, 110), 3);
    chk("hold_held100", hd[100][2], 1);
    chk("hold_held101", hd[101][2], 0);

    // Accel: spacing 3, 2, 1, 1 ticks after the first repeat
    sync_tick();
    accel_en  = 1'b1;
    btn_in[3] = 1'b1;
    run_to(125);
    btn_in[3] = 1'b0;
    run_to(130);
    accel_en = 1'b0;
    chk("acc_41", mv[41][3], 1);
    chk("acc_71", mv[71][3], 1);
    chk("acc_81", mv[81][3], 0);
    chk("acc_91", mv[91][3], 1);
    chk("acc_101", mv[101][3], 1);
    chk("acc_111", mv[111][3], 1);
    chk("acc_121", mv[121][3], 1);
    chk("acc_count", count(3, 1, 130), 7);

    // Opposing pair
    sync_tick();
    btn_in[0] = 1'b1;
    run_to(5);
    btn_in[1] = 1'b1;
    run_to(60);
    btn_in[1] = 1'b0;
    run_to(65);
    btn_in[0] = 1'b0;
    run_to(70);
    chk("opp_press", mv[1][0], 1);
    chk("opp_held6", hd[6][1:0], 0);
    chk("opp_ch0_quiet", count(0, 2, 60), 0);
    chk("opp_ch1_quiet", count(1, 1, 60), 0);
    chk("opp_held60", hd[60][1:0], 0);
    chk("opp_repress", mv[61][0], 1);
    chk("opp_reheld", hd[61][0], 1);

    // Enable drop in REPEAT, re-enable while held, then reset
    sync_tick();
    btn_in[2] = 1'b1;
    run_to(75);
    enable = 1'b0;
    run_to(85);
    enable = 1'b1;
    run_to(95);
    reset = 1'b1;
    run_to(96);
    reset = 1'b0;
    run_to(106);
    btn_in[2] = 1'b0;
    run_to(110);
    chk("en_in_repeat", mv[71][2], 1);
    chk("en_held75", hd[75][2], 1);
    chk("en_held76", hd[76][2], 0);
    chk("en_quiet", count(2, 76, 85), 0);
    chk("en_repress", mv[86][2], 1);
    chk("en_reheld", hd[86][2], 1);
    chk("rst_mid_move", mv[96], 0);
    chk("rst_mid_held", hd[96], 0);
    chk("rst_mid_tick", tk[96], 0);
    chk("rst_repress", mv[97][2], 1);
    chk("rst_pres104", tk[104], 0);
    chk("rst_pres105", tk[105], 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
